core_top_ds: RTL and testbench
==============================

// Module: core_top_ds
// PURPOSE
//  Single-issue, one-instruction-per-cycle 32-bit MIPS-subset core with one architectural branch delay slot.
//  Includes an instruction memory (instance imem), a CPU instance u_cpu and its register file u_cpu.u_reg_file.
//  Delay-slot activity is classified per branch as manual, NOP or auto-filled.
//  Event pulses and 32-bit statistics counters are exported for top-level monitors.
// PARAMETERS
//  IMEM_WORDS  256      instruction memory depth in 32-bit words; index = addr[..:2] modulo depth
//  RESET_PC    32'h0    PC loaded on reset; nPC loaded with RESET_PC+4
// PORTS
//  clk                     in   1   single clock, all state on rising edge
//  reset                   in   1   synchronous, active-high
//  branch_event_valid      out  1   1-cycle pulse while a branch's delay slot executes
//  branch_event_pc         out  32  PC of that branch
//  branch_event_taken      out  1   resolved branch outcome
//  slot_event_is_nop       out  1   slot executed as a NOP
//  slot_event_is_auto      out  1   slot was auto-filled
//  stat_cycle_count        out  32  cycles since reset released
//  stat_branch_count       out  32  branches executed
//  stat_slot_manual_count  out  32  slots with a useful instruction from the program
//  stat_slot_auto_count    out  32  auto-filled slots
//  stat_slot_nop_count     out  32  slots executed as NOP
// BEHAVIOUR
//  - Reset: PC=RESET_PC, nPC=RESET_PC+4; regs[0..31]=0; all counters and event outputs 0.
//    imem contents are preserved across reset.
//  - imem: combinational read; backdoor task imem.write_word(input [31:0] byte_addr, input [31:0] data).
//  - Each non-reset cycle executes the instruction at PC, writes the result at the edge, then PC<=nPC.
//    nPC<=(taken branch)?target:nPC+4.
//  - ISA:
//    R-type op 0: funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed).
//    addi op 0x08 (sign-extended imm). beq op 0x04, bne op 0x05.
//    0x00000000 and any unknown opcode act as NOP.
//  - Arithmetic wraps mod 2^32; no overflow traps.
//  - regs[0] reads 0 and ignores writes. Register array is named regs.
//  - Branch: target = branch PC + 4 + (sign-extended imm << 2). The next sequential instruction (slot) always executes.
//  - A branch inside a delay slot executes as NOP and is not itself counted as a branch.
//  - Slot classification, made in the slot cycle with exactly one flag true:
//    - manual: non-NOP slot instruction.
//    - nop: NOP slot, no auto-fill.
//    - auto: auto-filled slot (see CONFIGURATION).
//  - In the slot cycle, branch_event_valid=1 and pc/taken hold the owning branch's values; outputs are 0 otherwise.
//  - On the same clock edge, stat_branch_count and exactly one slot counter increment.
//  - stat_cycle_count increments every cycle with reset=0. All counters wrap at 2^32.
//  - Reset asserted mid-program: the pending slot is discarded and no event or count is produced.
// CONFIGURATION
//  AUTO_SLOT_FILL_EN defined:
//    - When a slot holds a NOP, the core executes the instruction that would run next: the target if taken, else PC+8.
//    - Next PC is then that instruction's PC+4.
//    - The fill is skipped (plain NOP) if that instruction is itself a branch.
//    - slot_event_is_auto=1; stat_slot_auto_count increments.
//  AUTO_SLOT_FILL_EN undefined:
//    - NOP slots execute as NOP.
//    - slot_event_is_auto and stat_slot_auto_count stay 0.
// TESTING
//  - Program: addi r1,r0,4; addi r2,r0,3; addi r3,r0,0; loop: add r3,r3,r2; addi r1,r1,-1; bne r1,r0,loop; addi r4,r4,1; add r6,r3,r0; nop.
//    Run 80 cycles -> r3=12, r4=4, r6=12, branches=4, manual=4, nop=0.
//  - Same program -> 4 events, pc=0x14, taken=1,1,1,0; each event: is_nop=0, is_auto=0.
//  - Replace the slot with NOP, no macro -> r4=0, r3=12, nop count=4.
//    With AUTO_SLOT_FILL_EN: r3=12, r6=12, auto=4, fewer cycles to reach 0x1C.
//  - beq r0,r0,+2 with slot addi r5,r0,7 -> r5=7, the skipped instruction is not executed, taken=1.
//  - addi r0,r0,5 -> regs[0] stays 0.
//    Reset held 5 cycles -> all counters 0, first fetch at RESET_PC.
//  - Reset asserted in the slot cycle -> no event pulse; counters 0 on the next cycle.

Source files
------------

// File: rtl/core_top_ds.sv
// MIPS-subset core with one branch delay slot, delay-slot classification and statistics.
// Optional build macro AUTO_SLOT_FILL_EN: a NOP slot executes the next instruction on the resolved path.

module core_imem #(
  parameter int IMEM_WORDS = 256
) (
  input  logic [31:0] addr_a,
  output logic [31:0] data_a,
  input  logic [31:0] addr_b,
  output logic [31:0] data_b
);
  localparam int AW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;

  logic [31:0] mem [IMEM_WORDS];

  assign data_a = mem[AW'((addr_a >> 2) % IMEM_WORDS)];
  assign data_b = mem[AW'((addr_b >> 2) % IMEM_WORDS)];

  // Backdoor loader; contents are deliberately untouched by reset.
  task write_word(input logic [31:0] byte_addr, input logic [31:0] data);
    mem[AW'((byte_addr >> 2) % IMEM_WORDS)] = data;
  endtask
endmodule

module core_reg_file (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra_a,
  input  logic [4:0]  ra_b,
  output logic [31:0] rd_a,
  output logic [31:0] rd_b,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] regs [32];

  assign rd_a = (ra_a == 5'd0) ? 32'd0 : regs[ra_a];
  assign rd_b = (ra_b == 5'd0) ? 32'd0 : regs[ra_b];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end
endmodule

// state   | meaning
// ST_RUN  | ordinary issue; a branch here opens a delay slot
// ST_SLOT | delay slot of the branch recorded in slot_pc_q/slot_taken_q
module core_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr_a,
  input  logic [31:0] imem_data_a,
  output logic [31:0] imem_addr_b,
  input  logic [31:0] imem_data_b,
  output logic        ev_valid,
  output logic [31:0] ev_pc,
  output logic        ev_taken,
  output logic        ev_is_nop,
  output logic        ev_is_auto,
  output logic [31:0] cnt_cycle,
  output logic [31:0] cnt_branch,
  output logic [31:0] cnt_manual,
  output logic [31:0] cnt_auto,
  output logic [31:0] cnt_nop
);
  typedef enum logic {ST_RUN, ST_SLOT} state_t;
  state_t state_q, state_d;

  logic [31:0] pc_q, pc_d, npc_q, npc_d, slot_pc_q, slot_pc_d;
  logic        slot_taken_q, slot_taken_d;
  logic [31:0] exec, rs_val, rt_val, imm_sext, alu_y, target;
  logic        slot_is_nop, do_fill, is_br_exec, taken, we;
  logic [4:0]  wa;
  logic        unused_shamt;

  function automatic logic is_branch(input logic [31:0] ins);
    return (ins[31:26] == 6'h04) || (ins[31:26] == 6'h05);
  endfunction

  function automatic logic is_alu(input logic [31:0] ins);
    if (ins[31:26] == 6'h08) return 1'b1;
    if (ins[31:26] != 6'h00) return 1'b0;
    return ins[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  endfunction

  assign imem_addr_a = pc_q;
  assign imem_addr_b = npc_q;

  // A branch sitting in a slot decodes as non-ALU, so it runs as a NOP.
  assign slot_is_nop = !is_alu(imem_data_a);
`ifdef AUTO_SLOT_FILL_EN
  assign do_fill = (state_q == ST_SLOT) && slot_is_nop && !is_branch(imem_data_b);
`else
  assign do_fill = 1'b0;
`endif
  assign exec       = do_fill ? imem_data_b : imem_data_a;
  assign is_br_exec = (state_q == ST_RUN) && is_branch(imem_data_a);
  assign imm_sext   = {{16{exec[15]}}, exec[15:0]};
  assign target     = pc_q + 32'd4 + (imm_sext << 2);
  assign taken      = (exec[31:26] == 6'h04) ? (rs_val == rt_val) : (rs_val != rt_val);
  assign we         = is_alu(exec);
  assign wa         = (exec[31:26] == 6'h00) ? exec[15:11] : exec[20:16];
  assign unused_shamt = ^exec[10:6];

  core_reg_file u_reg_file (
    .clk  (clk),
    .reset(reset),
    .ra_a (exec[25:21]),
    .ra_b (exec[20:16]),
    .rd_a (rs_val),
    .rd_b (rt_val),
    .we   (we),
    .wa   (wa),
    .wd   (alu_y)
  );

  always_comb begin
    alu_y = 32'd0;
    if (exec[31:26] == 6'h08) begin
      alu_y = rs_val + imm_sext;
    end else begin
      case (exec[5:0])
        6'h20:   alu_y = rs_val + rt_val;
        6'h22:   alu_y = rs_val - rt_val;
        6'h24:   alu_y = rs_val & rt_val;
        6'h25:   alu_y = rs_val | rt_val;
        6'h2A:   alu_y = {31'd0, $signed(rs_val) < $signed(rt_val)};
        default: alu_y = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = is_br_exec ? ST_SLOT : ST_RUN;
  end

  always_comb begin
    ev_valid   = (state_q == ST_SLOT) && !reset;
    ev_pc      = ev_valid ? slot_pc_q : 32'd0;
    ev_taken   = ev_valid && slot_taken_q;
    ev_is_auto = ev_valid && do_fill;
    ev_is_nop  = ev_valid && slot_is_nop && !do_fill;
  end

  always_comb begin
    pc_d         = npc_q;
    npc_d        = npc_q + 32'd4;
    slot_pc_d    = slot_pc_q;
    slot_taken_d = slot_taken_q;
    if (is_br_exec) begin
      slot_pc_d    = pc_q;
      slot_taken_d = taken;
      if (taken) npc_d = target;
    end
    // The filled instruction came from npc, so fetch resumes just past it.
    if (do_fill) begin
      pc_d  = npc_q + 32'd4;
      npc_d = npc_q + 32'd8;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      npc_q        <= RESET_PC + 32'd4;
      slot_pc_q    <= 32'd0;
      slot_taken_q <= 1'b0;
      cnt_cycle    <= 32'd0;
      cnt_branch   <= 32'd0;
      cnt_manual   <= 32'd0;
      cnt_auto     <= 32'd0;
      cnt_nop      <= 32'd0;
    end else begin
      pc_q         <= pc_d;
      npc_q        <= npc_d;
      slot_pc_q    <= slot_pc_d;
      slot_taken_q <= slot_taken_d;
      cnt_cycle    <= cnt_cycle + 32'd1;
      if (ev_valid) begin
        cnt_branch <= cnt_branch + 32'd1;
        if (ev_is_auto)     cnt_auto   <= cnt_auto + 32'd1;
        else if (ev_is_nop) cnt_nop    <= cnt_nop + 32'd1;
        else                cnt_manual <= cnt_manual + 32'd1;
      end
    end
  end
endmodule

module core_top_ds #(
  parameter int          IMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        branch_event_valid,
  output logic [31:0] branch_event_pc,
  output logic        branch_event_taken,
  output logic        slot_event_is_nop,
  output logic        slot_event_is_auto,
  output logic [31:0] stat_cycle_count,
  output logic [31:0] stat_branch_count,
  output logic [31:0] stat_slot_manual_count,
  output logic [31:0] stat_slot_auto_count,
  output logic [31:0] stat_slot_nop_count
);
  logic [31:0] addr_a, data_a, addr_b, data_b;

  core_imem #(.IMEM_WORDS(IMEM_WORDS)) imem (
    .addr_a(addr_a), .data_a(data_a), .addr_b(addr_b), .data_b(data_b)
  );

  core_cpu #(.RESET_PC(RESET_PC)) u_cpu (
    .clk        (clk),
    .reset      (reset),
    .imem_addr_a(addr_a),
    .imem_data_a(data_a),
    .imem_addr_b(addr_b),
    .imem_data_b(data_b),
    .ev_valid   (branch_event_valid),
    .ev_pc      (branch_event_pc),
    .ev_taken   (branch_event_taken),
    .ev_is_nop  (slot_event_is_nop),
    .ev_is_auto (slot_event_is_auto),
    .cnt_cycle  (stat_cycle_count),
    .cnt_branch (stat_branch_count),
    .cnt_manual (stat_slot_manual_count),
    .cnt_auto   (stat_slot_auto_count),
    .cnt_nop    (stat_slot_nop_count)
  );
endmodule

// File: tb/tb_core_top_ds.sv
// Scoreboard bench for core_top_ds: expected slot events are queued, a negedge monitor pops them.
module tb_core_top_ds;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ev_valid, ev_taken, ev_nop, ev_auto;
  logic [31:0] ev_pc, c_cycle, c_branch, c_manual, c_auto, c_nop;

  int checks = 0;
  int errors = 0;
  logic [34:0] exp_q[$];
  logic [31:0] prog [16];
  int          prog_len;

  always #5 clk = ~clk;

  core_top_ds dut (
    .clk                   (clk),
    .reset                 (reset),
    .branch_event_valid    (ev_valid),
    .branch_event_pc       (ev_pc),
    .branch_event_taken    (ev_taken),
    .slot_event_is_nop     (ev_nop),
    .slot_event_is_auto    (ev_auto),
    .stat_cycle_count      (c_cycle),
    .stat_branch_count     (c_branch),
    .stat_slot_manual_count(c_manual),
    .stat_slot_auto_count  (c_auto),
    .stat_slot_nop_count   (c_nop)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [34:0] e;
    if (ev_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL event_unexpected actual pc=%h taken=%b nop=%b auto=%b required none",
                 ev_pc, ev_taken, ev_nop, ev_auto);
      end else begin
        e = exp_q.pop_front();
        if ({ev_pc, ev_taken, ev_nop, ev_auto} !== e) begin
          errors++;
          $display("FAIL event actual pc=%h t/n/a=%b%b%b required pc=%h t/n/a=%b",
                   ev_pc, ev_taken, ev_nop, ev_auto, e[34:3], e[2:0]);
        end
      end
    end
  end

  task automatic push_ev(input logic [31:0] pc, input logic t, input logic n, input logic a);
    exp_q.push_back({pc, t, n, a});
  endtask

  task automatic start_prog();
    reset = 1'b1;
    for (int i = 0; i < 256; i++) dut.imem.write_word(i * 4, 32'h0);
    for (int i = 0; i < prog_len; i++) dut.imem.write_word(i * 4, prog[i]);
    repeat (5) @(posedge clk);
    #1;
    chk("rst_cycle", c_cycle, 32'd0);
    chk("rst_counts", c_branch | c_manual | c_auto | c_nop, 32'd0);
    chk("rst_pc", dut.u_cpu.pc_q, 32'h0);
    chk("rst_npc", dut.u_cpu.npc_q, 32'h4);
    chk("rst_r3", dut.u_cpu.u_reg_file.regs[3], 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_loop(input logic [31:0] slot);
    prog[0] = 32'h20010004; prog[1] = 32'h20020003; prog[2] = 32'h20030000;
    prog[3] = 32'h00621820; prog[4] = 32'h2021FFFF; prog[5] = 32'h1420FFFD;
    prog[6] = slot;         prog[7] = 32'h00603020; prog[8] = 32'h00000000;
    prog_len = 9;
  endtask

  task automatic load_beq();
    prog[0] = 32'h10000002; prog[1] = 32'h20050007;
    prog[2] = 32'h20070009; prog[3] = 32'h20080001;
    prog_len = 4;
  endtask

  initial begin
    int n;
    logic auto_on;
`ifdef AUTO_SLOT_FILL_EN
    auto_on = 1'b1;
`else
    auto_on = 1'b0;
`endif

    // Loop with a useful slot instruction.
    load_loop(32'h20840001);
    start_prog();
    push_ev(32'h14, 1, 0, 0); push_ev(32'h14, 1, 0, 0);
    push_ev(32'h14, 1, 0, 0); push_ev(32'h14, 0, 0, 0);
    run(80);
    chk("t1_r3", dut.u_cpu.u_reg_file.regs[3], 32'd12);
    chk("t1_r4", dut.u_cpu.u_reg_file.regs[4], 32'd4);
    chk("t1_r6", dut.u_cpu.u_reg_file.regs[6], 32'd12);
    chk("t1_branch", c_branch, 32'd4);
    chk("t1_manual", c_manual, 32'd4);
    chk("t1_nop", c_nop, 32'd0);
    chk("t1_auto", c_auto, 32'd0);
    chk("t1_cycle", c_cycle, 32'd80);
    chk("t1_events_left", exp_q.size(), 32'd0);

    // Same loop with a NOP slot.
    load_loop(32'h00000000);
    start_prog();
    push_ev(32'h14, 1, !auto_on, auto_on); push_ev(32'h14, 1, !auto_on, auto_on);
    push_ev(32'h14, 1, !auto_on, auto_on); push_ev(32'h14, 0, !auto_on, auto_on);
    n = 0;
    while (dut.u_cpu.pc_q < 32'h1C && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t2_cycles_to_1c", n, auto_on ? 32'd16 : 32'd19);
    run(80 - n);
    chk("t2_r3", dut.u_cpu.u_reg_file.regs[3], 32'd12);
    chk("t2_r4", dut.u_cpu.u_reg_file.regs[4], 32'd0);
    chk("t2_r6", dut.u_cpu.u_reg_file.regs[6], 32'd12);
    chk("t2_branch", c_branch, 32'd4);
    chk("t2_manual", c_manual, 32'd0);
    chk("t2_nop", c_nop, auto_on ? 32'd0 : 32'd4);
    chk("t2_auto", c_auto, auto_on ? 32'd4 : 32'd0);
    chk("t2_cycle", c_cycle, 32'd80);
    chk("t2_events_left", exp_q.size(), 32'd0);

    // beq r0,r0,+2 with a manual slot; the instruction at 0x08 is skipped.
    load_beq();
    start_prog();
    push_ev(32'h0, 1, 0, 0);
    run(20);
    chk("t3_r5", dut.u_cpu.u_reg_file.regs[5], 32'd7);
    chk("t3_r7", dut.u_cpu.u_reg_file.regs[7], 32'd0);
    chk("t3_r8", dut.u_cpu.u_reg_file.regs[8], 32'd1);
    chk("t3_branch", c_branch, 32'd1);
    chk("t3_manual", c_manual, 32'd1);
    chk("t3_events_left", exp_q.size(), 32'd0);

    // ALU operations, signed slt and writes to r0.
    prog[0] = 32'h2001FFFB; prog[1] = 32'h20020003; prog[2] = 32'h00221822;
    prog[3] = 32'h00222024; prog[4] = 32'h00222825; prog[5] = 32'h0022302A;
    prog[6] = 32'h0041382A; prog[7] = 32'h20000005; prog[8] = 32'h00224020;
    prog_len = 9;
    start_prog();
    run(20);
    chk("t4_sub", dut.u_cpu.u_reg_file.regs[3], 32'hFFFFFFF8);
    chk("t4_and", dut.u_cpu.u_reg_file.regs[4], 32'h00000003);
    chk("t4_or", dut.u_cpu.u_reg_file.regs[5], 32'hFFFFFFFB);
    chk("t4_slt_lt", dut.u_cpu.u_reg_file.regs[6], 32'd1);
    chk("t4_slt_ge", dut.u_cpu.u_reg_file.regs[7], 32'd0);
    chk("t4_add_neg", dut.u_cpu.u_reg_file.regs[8], 32'hFFFFFFFE);
    chk("t4_r0", dut.u_cpu.u_reg_file.regs[0], 32'd0);
    chk("t4_branch", c_branch, 32'd0);

    // Reset arriving during the slot cycle discards the pending slot.
    load_beq();
    start_prog();
    run(1);
    reset = 1'b1;
    #1;
    chk("t5_valid_in_reset", {31'd0, ev_valid}, 32'd0);
    run(1);
    chk("t5_cycle", c_cycle, 32'd0);
    chk("t5_branch", c_branch, 32'd0);
    chk("t5_manual", c_manual, 32'd0);
    chk("t5_pc", dut.u_cpu.pc_q, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    push_ev(32'h0, 1, 0, 0);
    run(20);
    chk("t5_r5", dut.u_cpu.u_reg_file.regs[5], 32'd7);
    chk("t5_branch_after", c_branch, 32'd1);
    chk("t5_events_left", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
